// File: rtl/i2c_reg_bridge.sv
// rtl/i2c_reg_bridge.sv - I2C-framed register file beside an i2c_peripheral
// Watches SCL/SDA, writes rx bytes into registers via a pointer byte, and serves tx on reads.
module i2c_reg_bridge #(
   parameter int NUM_REGS = 8,
   parameter int PTR_W    = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  scl_in,
   input  logic                  sda_in,
   input  logic [7:0]            rx,
   output logic [7:0]            tx,
   output logic [8*NUM_REGS-1:0] reg_out,
   output logic                  wr_strobe,
   output logic [PTR_W-1:0]      wr_addr,
   output logic [7:0]            wr_data,
   output logic [PTR_W-1:0]      ptr
);

   typedef enum logic [2:0] {IDLE, ADDR, PTR, WRITE, READ, IGNORE} state_t;

   state_t            state, state_nx;
   logic [2:0]        scl_sy, sda_sy;
   logic [3:0]        bit_cnt;
   logic              rw;
   logic              ack_ptr, ack_wr;
   logic [7:0]        regs [NUM_REGS];
   logic [PTR_W-1:0]  ptr_inc;
   logic              scl_rise, start_det, stop_det, bit_evt, ack_slot, sda_bit;

   // Index [1] is the synchronised level, [2] the previous one for edge detection.
   assign sda_bit   = sda_sy[1];
   assign scl_rise  = scl_sy[1] & ~scl_sy[2];
   assign start_det = scl_sy[1] & sda_sy[2] & ~sda_sy[1];
   assign stop_det  = scl_sy[1] & ~sda_sy[2] & sda_sy[1];
   assign bit_evt   = scl_rise & ~start_det & ~stop_det & (state != IDLE);
   assign ack_slot  = bit_evt & (bit_cnt == 4'd8);
   assign ptr_inc   = ptr + PTR_W'(1);

   always_comb begin
      reg_out = '0;
      for (int k = 0; k < NUM_REGS; k++) reg_out[8*k +: 8] = regs[k];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (start_det) begin
         state_nx = ADDR;
      end else if (stop_det) begin
         state_nx = IDLE;
      end else if (ack_slot) begin
         case (state)
            ADDR:    state_nx = sda_bit ? IGNORE : (rw ? READ : PTR);
            PTR:     state_nx = WRITE;
            READ:    state_nx = sda_bit ? IGNORE : READ;
            default: state_nx = state;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scl_sy    <= 3'b111;
         sda_sy    <= 3'b111;
         bit_cnt   <= 4'd0;
         rw        <= 1'b0;
         ack_ptr   <= 1'b0;
         ack_wr    <= 1'b0;
         tx        <= 8'h00;
         ptr       <= '0;
         wr_strobe <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= 8'h00;
         for (int k = 0; k < NUM_REGS; k++) regs[k] <= 8'h00;
      end else begin
         scl_sy    <= {scl_sy[1:0], scl_in};
         sda_sy    <= {sda_sy[1:0], sda_in};
         wr_strobe <= 1'b0;

         if (start_det || stop_det)
            bit_cnt <= 4'd0;
         else if (bit_evt)
            bit_cnt <= (bit_cnt == 4'd8) ? 4'd0 : bit_cnt + 4'd1;

         if (bit_evt && state == ADDR && bit_cnt == 4'd7) rw <= sda_bit;

         // rx settles on the same SCL rise, so it is consumed one clk after the ACK-slot detect.
         ack_ptr <= ack_slot && state == PTR;
         ack_wr  <= ack_slot && state == WRITE;

         if (ack_slot && state == ADDR && !sda_bit && rw) tx <= regs[ptr];
         if (ack_slot && state == READ) begin
            ptr <= ptr_inc;
            tx  <= regs[ptr_inc];
         end

         if (ack_ptr) ptr <= rx[PTR_W-1:0];
         if (ack_wr) begin
            regs[ptr] <= rx;
            wr_strobe <= 1'b1;
            wr_addr   <= ptr;
            wr_data   <= rx;
            ptr       <= ptr_inc;
         end
      end
   end

endmodule

// File: tb/tb_i2c_reg_bridge.sv
// tb/tb_i2c_reg_bridge.sv - directed I2C bus stimulus with a write-strobe scoreboard
// The bench plays both controller and the peripheral's rx/ACK behaviour.
module tb_i2c_reg_bridge;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        scl = 1'b1;
   logic        sda = 1'b1;
   logic [7:0]  rx = 8'h00;
   logic [7:0]  tx;
   logic [63:0] reg_out;
   logic        wr_strobe;
   logic [2:0]  wr_addr;
   logic [7:0]  wr_data;
   logic [2:0]  ptr;

   int n_checks = 0;
   int n_pass   = 0;
   int half     = 16;
   int skew     = 0;
   logic [10:0] exp_q[$];

   i2c_reg_bridge #(.NUM_REGS(8), .PTR_W(3)) dut (
      .clk(clk), .rst_n(rst_n), .scl_in(scl), .sda_in(sda), .rx(rx),
      .tx(tx), .reg_out(reg_out), .wr_strobe(wr_strobe), .wr_addr(wr_addr),
      .wr_data(wr_data), .ptr(ptr)
   );

   always #5 clk = ~clk;

   initial begin
      #3ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   always @(negedge clk) begin
      if (rst_n && wr_strobe) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            $display("FAIL wr_unexpected: got addr %0d data %h expected no write", wr_addr, wr_data);
         end else begin
            logic [10:0] e;
            e = exp_q.pop_front();
            if ({wr_addr, wr_data} === e) n_pass++;
            else $display("FAIL wr_event: got addr %0d data %h expected addr %0d data %h",
                          wr_addr, wr_data, e[10:8], e[7:0]);
         end
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic bus_start();
      wait_clk(half/2 + skew); sda = 1'b0;
      wait_clk(half - skew);   scl = 1'b0;
   endtask

   task automatic bus_rstart();
      wait_clk(half/2 + skew); sda = 1'b1;
      wait_clk(half/2 - skew); scl = 1'b1;
      wait_clk(half/2 + skew); sda = 1'b0;
      wait_clk(half/2 - skew); scl = 1'b0;
   endtask

   task automatic bus_stop();
      wait_clk(half/2 + skew); sda = 1'b0;
      wait_clk(half/2 - skew); scl = 1'b1;
      wait_clk(half/2 + skew); sda = 1'b1;
      wait_clk(half);
   endtask

   task automatic send_bit(input logic b);
      wait_clk(half/2 + skew); sda = b;
      wait_clk(half/2 - skew); scl = 1'b1;
      wait_clk(half);          scl = 1'b0;
   endtask

   // ack_low: SDA low in the ACK slot; upd_rx: peripheral presents the byte on rx at that rise.
   task automatic send_byte(input logic [7:0] b, input logic ack_low, input logic upd_rx);
      for (int i = 7; i >= 0; i--) send_bit(b[i]);
      wait_clk(half/2 + skew); sda = ~ack_low;
      wait_clk(half/2 - skew); scl = 1'b1;
      if (upd_rx) rx = b;
      wait_clk(half);          scl = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; scl = 1'b1; sda = 1'b1;
      wait_clk(4);
      rst_n = 1'b1;
      wait_clk(4);
   endtask

   task automatic run_s123(input string tag);
      // write burst
      bus_start();
      send_byte(8'h84, 1'b1, 1'b1);
      send_byte(8'h02, 1'b1, 1'b1);
      exp_q.push_back({3'd2, 8'hA5});
      send_byte(8'hA5, 1'b1, 1'b1);
      exp_q.push_back({3'd3, 8'h3C});
      send_byte(8'h3C, 1'b1, 1'b1);
      bus_stop();
      @(negedge clk);
      check({tag, "_s1_regs"}, reg_out, 64'h00000000_3CA50000);
      check({tag, "_s1_ptr"}, 64'(ptr), 64'd4);
      // pointer wrap and modulo
      bus_start();
      send_byte(8'h84, 1'b1, 1'b1);
      send_byte(8'h0F, 1'b1, 1'b1);
      exp_q.push_back({3'd7, 8'h11});
      send_byte(8'h11, 1'b1, 1'b1);
      exp_q.push_back({3'd0, 8'h22});
      send_byte(8'h22, 1'b1, 1'b1);
      bus_stop();
      @(negedge clk);
      check({tag, "_s2_regs"}, reg_out, 64'h11000000_3CA50022);
      check({tag, "_s2_ptr"}, 64'(ptr), 64'd1);
      // repeated-start read
      bus_start();
      send_byte(8'h84, 1'b1, 1'b1);
      send_byte(8'h03, 1'b1, 1'b1);
      bus_rstart();
      send_byte(8'h85, 1'b1, 1'b0);
      @(negedge clk);
      check({tag, "_s3_tx_reg3"}, 64'(tx), 64'h3C);
      check({tag, "_s3_ptr3"}, 64'(ptr), 64'd3);
      send_byte(8'hFF, 1'b1, 1'b0);
      @(negedge clk);
      check({tag, "_s3_tx_reg4"}, 64'(tx), 64'h00);
      check({tag, "_s3_ptr4"}, 64'(ptr), 64'd4);
      send_byte(8'hFF, 1'b0, 1'b0);
      @(negedge clk);
      check({tag, "_s3_ptr_nack"}, 64'(ptr), 64'd5);
      send_byte(8'hFF, 1'b1, 1'b0);
      bus_stop();
      @(negedge clk);
      check({tag, "_s3_ptr_ignored"}, 64'(ptr), 64'd5);
      check({tag, "_s3_tx_held"}, 64'(tx), 64'h00);
      check({tag, "_s3_regs"}, reg_out, 64'h11000000_3CA50022);
   endtask

   initial begin
      do_reset();
      @(negedge clk);
      check("rst_tx", 64'(tx), 64'h0);
      check("rst_regs", reg_out, 64'h0);
      check("rst_ptr", 64'(ptr), 64'h0);
      check("rst_wr", {wr_strobe, wr_addr, wr_data}, 64'h0);

      run_s123("nom");

      // unaddressed transaction
      bus_start();
      send_byte(8'h84, 1'b0, 1'b1);
      send_byte(8'h55, 1'b1, 1'b1);
      send_byte(8'h66, 1'b1, 1'b1);
      send_byte(8'h77, 1'b1, 1'b1);
      bus_stop();
      @(negedge clk);
      check("s4_ptr", 64'(ptr), 64'd5);
      check("s4_regs", reg_out, 64'h11000000_3CA50022);

      // STOP after a partial data byte
      bus_start();
      send_byte(8'h84, 1'b1, 1'b1);
      send_byte(8'h01, 1'b1, 1'b1);
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      bus_stop();
      @(negedge clk);
      check("s5_stop_ptr", 64'(ptr), 64'd1);
      check("s5_stop_regs", reg_out, 64'h11000000_3CA50022);

      // reset mid-byte
      bus_start();
      send_byte(8'h84, 1'b1, 1'b1);
      send_byte(8'h06, 1'b1, 1'b1);
      for (int i = 0; i < 4; i++) send_bit(1'b0);
      rst_n = 1'b0;
      wait_clk(3);
      @(negedge clk);
      check("s5_rst_regs", reg_out, 64'h0);
      check("s5_rst_ptr_tx", {ptr, tx}, 64'h0);
      check("s5_rst_wr", {wr_strobe, wr_addr, wr_data}, 64'h0);
      rst_n = 1'b1;
      wait_clk(2);
      bus_stop();
      bus_start();
      send_byte(8'h84, 1'b1, 1'b1);
      send_byte(8'h05, 1'b1, 1'b1);
      exp_q.push_back({3'd5, 8'h77});
      send_byte(8'h77, 1'b1, 1'b1);
      bus_stop();
      @(negedge clk);
      check("s5_after_regs", reg_out, 64'h00007700_00000000);
      check("s5_after_ptr", 64'(ptr), 64'd6);

      // 16x clock ratio with SDA skewed both ways
      half = 8;
      skew = 1;
      do_reset();
      run_s123("fast_p1");
      skew = -1;
      do_reset();
      run_s123("fast_m1");

      wait_clk(4);
      check("wr_pending", 64'(exp_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/i2c_reg_bridge.md
Name: i2c_reg_bridge

Overview:
- Downstream consumer of `i2c_peripheral`.
- Monitors the same SCL/SDA lines through synchronisers and frames I2C transactions in the system clock domain.
- Captures each received byte from the peripheral's `rx` output and maintains a small register file addressed by a pointer byte.
- Drives the peripheral's `tx` byte for controller reads.

Parameters:
- NUM_REGS, 8, number of 8-bit registers; must be a power of two.
- PTR_W, 3, pointer width; equals log2(NUM_REGS).

Ports:
- clk  input  1  system clock; f_clk ≥ 16 × f_SCL.
- rst_n  input  1  asynchronous, active-low reset.
- scl_in  input  1  read-only copy of SCL; asynchronous.
- sda_in  input  1  read-only copy of SDA; asynchronous.
- rx  input  8  byte from `i2c_peripheral.rx`; stable for ≥ 8 SCL periods after the data ACK edge.
- tx  output  8  byte to `i2c_peripheral.tx`.
- reg_out  output  8*NUM_REGS  flattened register file; reg k at bits [8k+7:8k].
- wr_strobe  output  1  one-cycle pulse per register write.
- wr_addr  output  PTR_W  register index written.
- wr_data  output  8  value written.
- ptr  output  PTR_W  current register pointer.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Registers, ptr, wr_strobe, wr_addr, wr_data and tx go to 0.
  - State goes to IDLE; bit counter goes to 0.
  - Reset asserted mid-transaction discards all partial state.
- Input conditioning:
  - scl_in and sda_in each pass through a 2-FF synchroniser.
  - A third flop per line provides edge detection.
  - START: synchronised SDA falls while synchronised SCL is high.
  - STOP: synchronised SDA rises while synchronised SCL is high.
  - SCL rise: synchronised SCL goes 0→1.
- Bit counter:
  - Range 0..8; increments on each SCL rise while in a framed state.
  - On the 9th rise (count 8, the ACK slot) it evaluates the byte and returns to 0.
- States: IDLE, ADDR, PTR, WRITE, READ, IGNORE.
- START, from any state including a repeated START:
  - Go to ADDR and clear the counter.
  - ptr is preserved.
- STOP, from any state:
  - Go to IDLE.
  - A partial byte is discarded with no write.
- ADDR:
  - Latch SDA on the 8th rise as rw.
  - On the 9th rise:
    - SDA low (peripheral ACKed) and rw=0 → PTR.
    - SDA low and rw=1 → READ; tx ← reg[ptr].
    - SDA high → IGNORE.
- PTR, on the 9th rise:
  - ptr ← rx[PTR_W-1:0], i.e. the pointer byte modulo NUM_REGS.
  - Go to WRITE.
- WRITE, on the 9th rise:
  - reg[ptr] ← rx.
  - wr_strobe=1 for one clk, with wr_addr=ptr (pre-increment) and wr_data=rx.
  - ptr ← ptr+1, wrapping NUM_REGS-1 → 0.
- rx sampling:
  - The peripheral updates rx on that same SCL rise, so rx is sampled 1 clk after the synchronised-edge detect.
  - This is a deliberate extra pipeline flop, not 0 cycles.
- READ, on the 9th rise:
  - ptr ← ptr+1 with wrap; tx ← reg[new ptr].
  - SDA high (controller NACK) → IGNORE; SDA low → stay in READ.
  - tx is updated within 4 clk of the raw SCL rise. It must be stable before the next SCL fall, which is guaranteed by the clock ratio.
- IGNORE: no register or pointer effect; exit only via START or STOP.
- IDLE: SCL edges are ignored.
- Held outputs:
  - tx holds its value outside READ.
  - reg_out changes only on a write.
- Simultaneous events:
  - START and STOP cannot coincide.
  - An SCL rise in the same clk as a START or STOP is ignored; START/STOP take priority.

Test Plan:
1. Write burst: START, 0x84 (addr 0x42, W, ACKed), ptr 0x02, data 0xA5, 0x3C, STOP → reg2=0xA5, reg3=0x3C; two wr_strobe pulses (addr 2 then 3); ptr=4.
2. Pointer wrap and modulo:
   - ptr byte 0x0F then data 0x11, 0x22 → reg7=0x11, reg0=0x22, ptr=1.
3. Repeated-start read:
   - Write ptr 0x03, repeated START, 0x85 (R, ACKed) → tx=reg3 before the first data SCL fall.
   - Controller ACKs → tx=reg4.
   - Controller NACKs → IGNORE; further SCL clocks change nothing.
4. Unaddressed transaction:
   - Address byte with SDA high at the 9th rise, then 3 data bytes → no wr_strobe; registers and ptr unchanged.
5. Aborts:
   - STOP after 4 data bits → no write; state IDLE.
   - rst_n pulsed low mid-byte → all outputs 0; the next complete transaction works normally.
6. Clock-ratio corner: f_clk = 16 × f_SCL with SCL/SDA skewed ±1 clk → all of scenarios 1–3 pass unchanged.
